fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, a one-entry skid
// buffer for downstream stalls, and flush/refetch on redirect.
module fetch_unit #(
   parameter int                     PC_WIDTH          = 32,
   parameter int                     INSTRUCTION_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_VECTOR      = PC_WIDTH'(32'hBFC00000)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          redirect,
   input  logic [PC_WIDTH-1:0]           redirect_pc,
   output logic                          imem_req,
   output logic [PC_WIDTH-1:0]           imem_addr,
   input  logic                          imem_ack,
   input  logic [INSTRUCTION_WIDTH-1:0]  imem_rdata,
   output logic [PC_WIDTH-1:0]           pc_out,
   output logic [INSTRUCTION_WIDTH-1:0]  instr_out,
   output logic                          fetch_valid,
   output logic                          fault
);

   localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(32'h00000013);

   localparam logic [1:0] ST_FETCH   = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   logic [1:0]                   r_state;
   logic [PC_WIDTH-1:0]          r_fetchPc;
   logic [PC_WIDTH-1:0]          r_staleAddr;
   logic [PC_WIDTH-1:0]          r_bufPc;
   logic [INSTRUCTION_WIDTH-1:0] r_bufInstr;
   logic [PC_WIDTH-1:0]          r_pcOut;
   logic [INSTRUCTION_WIDTH-1:0] r_instrOut;
   logic                         r_fetchValid;
   logic                         r_fault;

   logic                         w_ack;
   logic [PC_WIDTH-1:0]          w_pcNext;
   logic [PC_WIDTH-1:0]          w_redirectAligned;
   logic                         w_misaligned;

   // No request goes out while reset is asserted, so a late ack is ignored.
   assign imem_req          = rst && (r_state != ST_HOLD);
   assign imem_addr         = (r_state == ST_DISCARD) ? r_staleAddr : r_fetchPc;
   assign w_ack             = imem_ack && imem_req;
   assign w_pcNext          = r_fetchPc + PC_WIDTH'(4);
   assign w_redirectAligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};
   assign w_misaligned      = (redirect_pc[1:0] != 2'b00);

   assign pc_out      = r_pcOut;
   assign instr_out   = r_instrOut;
   assign fetch_valid = r_fetchValid;
   assign fault       = r_fault;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= ST_FETCH;
         r_fetchPc    <= RESET_VECTOR;
         r_staleAddr  <= RESET_VECTOR;
         r_bufPc      <= '0;
         r_bufInstr   <= NOP;
         r_pcOut      <= RESET_VECTOR;
         r_instrOut   <= NOP;
         r_fetchValid <= 1'b0;
         r_fault      <= 1'b0;
      end else if (redirect) begin
         // Redirect beats stall and ack; an unacked request must still be drained.
         r_fetchPc    <= w_redirectAligned;
         r_instrOut   <= NOP;
         r_fetchValid <= 1'b0;
         r_bufPc      <= '0;
         r_bufInstr   <= NOP;
         if (w_misaligned) begin
            r_fault <= 1'b1;
         end
         case (r_state)
            ST_FETCH: begin
               if (!w_ack) begin
                  r_state     <= ST_DISCARD;
                  r_staleAddr <= r_fetchPc;
               end
            end
            ST_HOLD: begin
               r_state <= ST_FETCH;
            end
            ST_DISCARD: begin
               if (w_ack) begin
                  r_state <= ST_FETCH;
               end
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_ack && !stall) begin
                  r_pcOut      <= r_fetchPc;
                  r_instrOut   <= imem_rdata;
                  r_fetchValid <= 1'b1;
                  r_fetchPc    <= w_pcNext;
               end else if (w_ack && stall) begin
                  r_bufPc    <= r_fetchPc;
                  r_bufInstr <= imem_rdata;
                  r_fetchPc  <= w_pcNext;
                  r_state    <= ST_HOLD;
               end else if (!stall) begin
                  r_instrOut   <= NOP;
                  r_fetchValid <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  r_pcOut      <= r_bufPc;
                  r_instrOut   <= r_bufInstr;
                  r_fetchValid <= 1'b1;
                  r_bufPc      <= '0;
                  r_bufInstr   <= NOP;
                  r_state      <= ST_FETCH;
               end
            end
            ST_DISCARD: begin
               if (w_ack) begin
                  r_state <= ST_FETCH;
               end
            end
            default: begin
               r_state <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by randomized stall/redirect/reset traffic, all
// checked against a program-order PC stream model and a latency-driven memory.
module tb_fetch_unit;

   localparam logic [31:0] RV  = 32'hBFC00000;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out;
   logic [31:0] instr_out;
   logic        fetch_valid;
   logic        fault;

   int checks   = 0;
   int failures = 0;

   fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .pc_out      (pc_out),
      .instr_out   (instr_out),
      .fetch_valid (fetch_valid),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Memory acks once a request has waited effLat cycles (0 = same cycle).
   int baseLat  = 0;
   bit randMode = 1'b0;
   int curLat   = 0;
   int waitCnt  = 0;
   int effLat;
   assign effLat     = randMode ? curLat : baseLat;
   assign imem_ack   = imem_req && (waitCnt >= effLat);
   assign imem_rdata = memWord(imem_addr);

   always @(posedge clk) begin
      if (!imem_req || imem_ack) waitCnt <= 0;
      else                       waitCnt <= waitCnt + 1;
      if (imem_ack) curLat <= $urandom_range(0, 3);
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitValid(input string tag, input int maxCycles);
      int n = 0;
      while (fetch_valid !== 1'b1 && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput(tag, {31'b0, fetch_valid}, 32'd1);
   endtask

   // Reference model: expected program-order PC stream and sticky fault.
   logic        eRst, eStall, eRedir, eReq, eAck, eValid;
   logic [31:0] eRpc, eAddr, ePc, eInstr;
   logic [31:0] expPc     = RV;
   bit          expFault  = 1'b0;
   int          consumed  = 0;

   always @(posedge clk) begin
      eRst   = rst;
      eStall = stall;
      eRedir = redirect;
      eRpc   = redirect_pc;
      eReq   = imem_req;
      eAck   = imem_ack;
      eAddr  = imem_addr;
      ePc    = pc_out;
      eInstr = instr_out;
      eValid = fetch_valid;
   end

   always @(negedge clk) begin
      if (eRst !== 1'b1) begin
         expPc    = RV;
         expFault = 1'b0;
         checkOutput("rstValid", {31'b0, fetch_valid}, 32'd0);
         checkOutput("rstPc", pc_out, RV);
         checkOutput("rstInstr", instr_out, NOP);
         checkOutput("rstFault", {31'b0, fault}, 32'd0);
      end else begin
         if (eRedir) begin
            if (eRpc[1:0] != 2'b00) expFault = 1'b1;
            expPc = {eRpc[31:2], 2'b00};
            checkOutput("redirValid", {31'b0, fetch_valid}, 32'd0);
            checkOutput("redirInstr", instr_out, NOP);
         end else if (eStall) begin
            checkOutput("stallPc", pc_out, ePc);
            checkOutput("stallInstr", instr_out, eInstr);
            checkOutput("stallValid", {31'b0, fetch_valid}, {31'b0, eValid});
         end else if (fetch_valid === 1'b1) begin
            checkOutput("streamPc", pc_out, expPc);
            checkOutput("streamInstr", instr_out, memWord(expPc));
            expPc = expPc + 32'd4;
            consumed++;
         end else begin
            checkOutput("bubbleInstr", instr_out, NOP);
            checkOutput("bubblePc", pc_out, ePc);
         end
         if (eReq && !eAck && rst) begin
            checkOutput("pendReq", {31'b0, imem_req}, 32'd1);
            checkOutput("pendAddr", imem_addr, eAddr);
         end
         checkOutput("fault", {31'b0, fault}, {31'b0, expFault});
      end
   end

   logic [31:0] staleAddr;

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      baseLat = 0; randMode = 1'b0;

      // Reset release with zero-wait memory streams consecutive PCs.
      tick(); tick();
      checkOutput("rstNoReq", {31'b0, imem_req}, 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("firstReq", {31'b0, imem_req}, 32'd1);
      checkOutput("firstAddr", imem_addr, RV);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("seqValid", {31'b0, fetch_valid}, 32'd1);
         checkOutput("seqPc", pc_out, RV + 32'(4 * i));
         checkOutput("seqInstr", instr_out, memWord(RV + 32'(4 * i)));
      end

      // Slow memory: two bubbles with the request address held.
      rst = 1'b0; baseLat = 2;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("slowBubble", {31'b0, fetch_valid}, 32'd0);
         checkOutput("slowNop", instr_out, NOP);
         checkOutput("slowAddr", imem_addr, RV);
      end
      tick();
      checkOutput("slowValid", {31'b0, fetch_valid}, 32'd1);
      checkOutput("slowPc", pc_out, RV);

      // Stall while the next word arrives: buffered, then released.
      baseLat = 0; stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("holdNoReq", {31'b0, imem_req}, 32'd0);
         checkOutput("holdPc", pc_out, RV);
      end
      stall = 1'b0;
      tick();
      checkOutput("releasePc", pc_out, RV + 32'd4);
      checkOutput("releaseInstr", instr_out, memWord(RV + 32'd4));
      tick();
      checkOutput("resumePc", pc_out, RV + 32'd8);

      // Redirect with a request pending drains the stale fetch.
      baseLat = 100;
      tick();
      staleAddr = imem_addr;
      redirect = 1'b1; redirect_pc = 32'h80000100;
      tick();
      redirect = 1'b0;
      checkOutput("discValid", {31'b0, fetch_valid}, 32'd0);
      checkOutput("discAddr", imem_addr, staleAddr);
      baseLat = 1;
      tick();
      checkOutput("discDrop", {31'b0, fetch_valid}, 32'd0);
      waitValid("discTimeout", 10);
      checkOutput("discPc", pc_out, 32'h80000100);

      // Misaligned redirect sets sticky fault; PC wraps at the top.
      baseLat = 0;
      tick();
      redirect = 1'b1; redirect_pc = 32'h80000102;
      tick();
      redirect = 1'b0;
      checkOutput("misFault", {31'b0, fault}, 32'd1);
      checkOutput("misAddr", imem_addr, 32'h80000100);
      waitValid("misTimeout", 5);
      checkOutput("misPc", pc_out, 32'h80000100);
      redirect = 1'b1; redirect_pc = 32'hFFFFFFFC;
      tick();
      redirect = 1'b0;
      waitValid("wrapTimeout", 5);
      checkOutput("wrapTop", pc_out, 32'hFFFFFFFC);
      tick();
      checkOutput("wrapZero", pc_out, 32'h00000000);
      checkOutput("faultSticky", {31'b0, fault}, 32'd1);

      // Reset during HOLD discards the buffered word.
      stall = 1'b1;
      tick();
      checkOutput("hold2NoReq", {31'b0, imem_req}, 32'd0);
      rst = 1'b0;
      tick();
      checkOutput("rstHoldPc", pc_out, RV);
      checkOutput("rstHoldValid", {31'b0, fetch_valid}, 32'd0);
      checkOutput("rstHoldFault", {31'b0, fault}, 32'd0);
      rst = 1'b1; stall = 1'b0;
      tick();
      checkOutput("afterRstPc", pc_out, RV);
      checkOutput("afterRstValid", {31'b0, fetch_valid}, 32'd1);

      // Random traffic checked continuously by the model.
      randMode = 1'b1;
      consumed = 0;
      for (int i = 0; i < 1500; i++) begin
         stall    = ($urandom_range(0, 9) < 3);
         redirect = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_pc = 32'hFFFFFFF8;
            1:       redirect_pc = $urandom;
            default: redirect_pc = $urandom & 32'hFFFFFFFC;
         endcase
         rst = ($urandom_range(0, 199) != 0);
         tick();
      end
      rst = 1'b1; stall = 1'b0; redirect = 1'b0;
      tick();
      checkOutput("progress", {31'b0, consumed > 100}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
